// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine front end: coin codes,
// coin-acceptor FSM states and a width helper.
package vm_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_FIVE = 2'b01;
   localparam logic [1:0] COIN_TEN  = 2'b10;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FLUSH   = 2'd1,
      GAP     = 2'd2
   } acc_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/coin_sensor.sv
// One coin-slot sensor: 2-flop synchroniser, debounce, high-time jam
// detection and a falling-edge coin event (jammed falls become a reject).
module coin_sensor
   import vm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int JAM_CYCLES      = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic event_o,
   output logic jam_rej_o,
   output logic jam_o
);

   localparam int DW = clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = clog2(JAM_CYCLES + 2);

   logic          s1_q, s2_q;
   logic          deb_q, deb_d;
   logic          jam_q, jam_d;
   logic          fall;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;

   always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      if (s2_q != deb_q) begin
         if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) deb_d = s2_q;
         else                                    dcnt_d = dcnt_q + 1'b1;
      end
      fall = deb_q & ~deb_d;

      // Saturate one past the limit so "exceeds JAM_CYCLES" stays visible.
      hcnt_d = '0;
      if (deb_q) hcnt_d = (hcnt_q == HW'(JAM_CYCLES + 1)) ? hcnt_q : hcnt_q + 1'b1;

      jam_d = jam_q | (deb_q & (hcnt_q >= HW'(JAM_CYCLES)));
      if (fall) jam_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         deb_q  <= 1'b0;
         dcnt_q <= '0;
         hcnt_q <= '0;
         jam_q  <= 1'b0;
      end else begin
         s1_q   <= raw_i;
         s2_q   <= s1_q;
         deb_q  <= deb_d;
         dcnt_q <= dcnt_d;
         hcnt_q <= hcnt_d;
         jam_q  <= jam_d;
      end
   end

   assign event_o   = fall & ~jam_q;
   assign jam_rej_o = fall & jam_q;
   assign jam_o     = jam_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: filters sensor events into a small FIFO and releases the
// queued coins as one gap-free burst so the vending FSM never sees a stray 00.
module coin_acceptor
   import vm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int JAM_CYCLES      = 64,
   parameter int WINDOW_CYCLES   = 16,
   parameter int GAP_CYCLES      = 2,
   parameter int QDEPTH          = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    coin5_raw,
   input  logic                    coin10_raw,
   input  logic                    accept_en,
   output logic [1:0]              coin_code,
   output logic                    reject,
   output logic                    jam,
   output logic [clog2(QDEPTH):0]  q_count
);

   localparam int AW = clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam int WW = clog2(WINDOW_CYCLES + 1);
   localparam int GW = clog2(GAP_CYCLES + 1);

   logic              ev5, ev10, jr5, jr10, jam5, jam10;
   logic              one_ev, empty, full, push, pop;
   logic [QDEPTH-1:0] mem_q;
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic [1:0]        code_q, code_d;
   logic              rej_q, rej_d;
   acc_state_e        state_q, state_d;

   coin_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_s5 (
      .clk(clk), .rst(rst), .raw_i(coin5_raw),
      .event_o(ev5), .jam_rej_o(jr5), .jam_o(jam5)
   );

   coin_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_s10 (
      .clk(clk), .rst(rst), .raw_i(coin10_raw),
      .event_o(ev10), .jam_rej_o(jr10), .jam_o(jam10)
   );

   always_comb begin
      empty  = (cnt_q == '0);
      full   = (cnt_q == CW'(QDEPTH));
      one_ev = ev5 ^ ev10;
      pop    = (state_q == FLUSH) && !empty;
      // A full queue still takes a coin if an entry leaves in the same cycle.
      push   = one_ev && accept_en && (!full || pop);
      rej_d  = (ev5 & ev10) | (one_ev & ~push) | jr5 | jr10;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = '0;
      gcnt_d  = '0;
      code_d  = COIN_NONE;
      case (state_q)
         COLLECT: begin
            if (!empty && (wcnt_q == WW'(WINDOW_CYCLES) || full)) state_d = FLUSH;
            else if (!push && !empty)                              wcnt_d  = wcnt_q + 1'b1;
         end
         FLUSH: begin
            if (empty) state_d = GAP;
            else       code_d  = mem_q[rptr_q] ? COIN_TEN : COIN_FIVE;
         end
         GAP: begin
            if (gcnt_q == GW'(GAP_CYCLES - 1)) state_d = COLLECT;
            else                               gcnt_d  = gcnt_q + 1'b1;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         gcnt_q  <= '0;
         code_q  <= COIN_NONE;
         rej_q   <= 1'b0;
         state_q <= COLLECT;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= ev10;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         gcnt_q  <= gcnt_d;
         code_q  <= code_d;
         rej_q   <= rej_d;
         state_q <= state_d;
      end
   end

   assign coin_code = code_q;
   assign reject    = rej_q;
   assign jam       = jam5 | jam10;
   assign q_count   = cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised bench for coin_acceptor against a coin-level reference model.
module tb_coin_acceptor;

   localparam int DEB = 4;
   localparam int JAM = 64;
   localparam int WIN = 16;
   localparam int GAP = 2;
   localparam int QD  = 4;

   logic       clk = 1'b0;
   logic       rst, c5, c10, acc;
   logic [1:0] code;
   logic       rej, jam;
   logic [2:0] qc;

   always #5 clk = ~clk;

   coin_acceptor dut (
      .clk(clk), .rst(rst), .coin5_raw(c5), .coin10_raw(c10), .accept_en(acc),
      .coin_code(code), .reject(rej), .jam(jam), .q_count(qc)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: sensor level tracks synced sample history and time high;
   // acceptor level keeps coins in a queue and a coarse mode (0 collect, 1 flush, 2 gap).
   bit         m_s1[2], m_s2[2], m_deb[2];
   bit         hist[2][$];
   int         m_high[2];
   bit         m_q[$];
   int         m_mode, m_idle, m_gap;
   logic [1:0] e_code;
   bit         e_rej;

   always @(posedge clk) begin
      bit raw[2];
      bit ev[2], jr[2];
      bit was_jam, flip, pop, push, one;
      int sz;
      raw[0] = c5;
      raw[1] = c10;
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            m_s1[s] = 0; m_s2[s] = 0; m_deb[s] = 0; m_high[s] = 0;
            hist[s].delete();
         end
         m_q.delete();
         m_mode = 0; m_idle = 0; m_gap = 0;
         e_code = 2'b00; e_rej = 0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            was_jam = m_deb[s] && (m_high[s] > JAM);
            hist[s].push_back(m_s2[s]);
            if (hist[s].size() > DEB) void'(hist[s].pop_front());
            flip = (hist[s].size() == DEB);
            for (int k = 0; k < hist[s].size(); k++)
               if (hist[s][k] == m_deb[s]) flip = 0;
            ev[s] = flip && m_deb[s] && !was_jam;
            jr[s] = flip && m_deb[s] && was_jam;
            if (m_deb[s]) m_high[s]++; else m_high[s] = 0;
            if (flip) m_deb[s] = !m_deb[s];
            m_s2[s] = m_s1[s];
            m_s1[s] = raw[s];
         end
         sz    = m_q.size();
         pop   = (m_mode == 1) && (sz > 0);
         one   = ev[0] ^ ev[1];
         push  = one && acc && (sz < QD || pop);
         e_rej = (ev[0] && ev[1]) || (one && !push) || jr[0] || jr[1];
         e_code = 2'b00;
         case (m_mode)
            0: begin
               if (sz > 0 && (m_idle == WIN || sz == QD)) begin m_mode = 1; m_idle = 0; end
               else if (push || sz == 0) m_idle = 0;
               else m_idle++;
            end
            1: begin
               if (sz == 0) begin m_mode = 2; m_gap = 0; end
               else e_code = m_q[0] ? 2'b10 : 2'b01;
            end
            default: begin
               if (m_gap == GAP - 1) m_mode = 0; else m_gap++;
            end
         endcase
         if (pop)  void'(m_q.pop_front());
         if (push) m_q.push_back(ev[1]);
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("coin_code", code, e_code);
         chk("reject", rej, e_rej);
         chk("jam", jam, (m_deb[0] && m_high[0] > JAM) || (m_deb[1] && m_high[1] > JAM));
         chk("q_count", qc, m_q.size());
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int s, input bit v);
      if (s == 0)      c5  = v;
      else if (s == 1) c10 = v;
      else begin c5 = v; c10 = v; end
   endtask

   // Coin with two cycles of random bounce at each edge.
   task automatic coin(input int s, input int hold);
      for (int i = 0; i < 2; i++) begin drive(s, 1'($urandom_range(0, 1))); idle(1); end
      drive(s, 1'b1);
      idle(hold);
      for (int i = 0; i < 2; i++) begin drive(s, 1'($urandom_range(0, 1))); idle(1); end
      drive(s, 1'b0);
   endtask

   initial begin
      c5 = 0; c10 = 0; acc = 1; rst = 1;
      idle(3);
      rst = 0;
      chk("rst_code", code, 2'b00);
      chk("rst_reject", rej, 1'b0);
      chk("rst_jam", jam, 1'b0);
      chk("rst_qcount", qc, 3'd0);
      checking = 1;

      coin(0, 10); idle(40);                      // single coin
      coin(1, 6); coin(0, 4); idle(40);           // ten then five in one burst
      coin(1, 100); idle(30);                     // jam then release
      repeat (3) begin coin(0, 5); idle(3); end   // fill queue, then overflow
      c5 = 1; idle(1); c10 = 1; idle(6); c5 = 0; idle(1); c10 = 0;
      idle(40);
      drive(2, 1); idle(8); drive(2, 0); idle(30); // simultaneous coins
      acc = 0; coin(0, 6); idle(10); acc = 1; idle(20);

      coin(0, 4); coin(1, 4); coin(0, 4);          // reset while flushing
      for (int i = 0; i < 100 && m_mode != 1; i++) idle(1);
      chk("flush_qcount", qc, 3'd3);
      rst = 1; idle(1); rst = 0;
      chk("rstflush_code", code, 2'b00);
      chk("rstflush_qcount", qc, 3'd0);
      idle(30);

      for (int it = 0; it < 300; it++) begin
         int s, hold;
         s    = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
         hold = ($urandom_range(0, 19) == 0) ? 80 : int'($urandom_range(3, 12));
         acc  = ($urandom_range(0, 6) != 0);
         coin(s, hold);
         idle($urandom_range(0, 20));
      end
      idle(40);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
